clk_monitor: RTL and testbench
==============================

CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 Parameter EXP_CYCLES, default 50000000, expected clk_in period in clk cycles (1 Hz at 50 MHz).
REQ-002 Parameter TOL_CYCLES, default 500000, allowed period deviation in clk cycles, ±.
REQ-003 Parameter CNT_W, default 27, width of the period counter and the period output; must hold EXP_CYCLES+TOL_CYCLES+1.
REQ-004 clk  input  1  system clock, one clock domain, all logic on posedge.
REQ-005 reset_button  input  1  synchronous, active-low reset.
REQ-006 clk_in  input  1  slow clock under test, asynchronous to clk.
REQ-007 tick  output  1  one-cycle pulse per detected clk_in rising edge.
REQ-008 period  output  CNT_W  last measured period in clk cycles.
REQ-009 period_valid  output  1  one-cycle pulse when period updates.
REQ-010 in_range  output  1  level: last period within EXP_CYCLES±TOL_CYCLES.
REQ-011 lost  output  1  level: clk_in missing (timeout).

Function
REQ-012 clk_in SHALL pass a 2-flop synchronizer, then a previous-value flop; rise = sync2 & ~prev.
REQ-013 tick SHALL be registered and assert on the 3rd clk edge after the first edge that samples clk_in high.
REQ-014 Counter cnt SHALL clear to 0 on a rise cycle, otherwise increment by 1, saturating at EXP_CYCLES+TOL_CYCLES.
REQ-015 Period SHALL equal the number of clk cycles between consecutive rises (cnt+1 at the rise); two rises 100 cycles apart yield period=100.
REQ-016 FSM states: IDLE, MEASURE, LOST.
REQ-017 IDLE: a rise → MEASURE, with tick but no period_valid.
REQ-018 MEASURE: a rise → period updated, period_valid pulse, in_range = (|period−EXP_CYCLES| ≤ TOL_CYCLES); stay in MEASURE.
REQ-019 IDLE or MEASURE: no rise while cnt == EXP_CYCLES+TOL_CYCLES → LOST next cycle; lost=1, in_range=0, period holds.
REQ-020 Simultaneous rise and cnt == EXP_CYCLES+TOL_CYCLES: the rise wins → period=EXP_CYCLES+TOL_CYCLES+1, in_range=0, stay in MEASURE.
REQ-021 LOST: a rise → MEASURE, lost=0, tick, no period_valid (the interval is invalid); the next rise produces a valid period.
REQ-022 period_valid and in_range SHALL update in the same cycle as tick.
REQ-023 Period arithmetic SHALL be unsigned CNT_W wide; the deviation comparison SHALL not wrap.

Reset
REQ-024 With reset_button=0 at a clk edge: state=IDLE, cnt=0, sync/prev flops=0, tick=0, period=0, period_valid=0, in_range=0, lost=0.
REQ-025 Reset SHALL abort any measurement in progress; no period_valid is produced for an interval spanning reset.
REQ-026 If clk_in is high across reset release, the resulting spurious rise SHALL only move IDLE→MEASURE and produce no period.

Structure
REQ-027 Package clk_monitor_pkg SHALL hold the FSM state enum and the default EXP_CYCLES/TOL_CYCLES constants.
REQ-028 The synchronizer and edge detector SHALL be sub-module sync_rise_detect (inputs clk, reset_button, async_in; output rise).
REQ-029 Target size: 120-400 lines RTL.

Verification (EXP_CYCLES=100, TOL_CYCLES=5, CNT_W=8)
REQ-030 Reset, then clk_in period 100 cycles → 1st rise: tick only; 2nd rise: period=100, period_valid=1, in_range=1, lost=0.
REQ-031 Periods 105, then 106, then 95, then 94 → in_range = 1, 0, 1, 0 respectively; period matches each value exactly.
REQ-032 Stop clk_in low after a rise → lost=1 the cycle after cnt reaches 105; period and tick held; a rise at cnt=105 instead gives period=106, in_range=0, lost=0.
REQ-033 From LOST, apply rises 100 cycles apart → 1st: lost=0, tick, no period_valid; 2nd: period=100, in_range=1.
REQ-034 Assert reset_button=0 at cnt=50 mid-measurement → all outputs reach their reset values; the next rise gives no period_valid.
REQ-035 clk_in held high through reset release → one tick 3 cycles after release, state MEASURE, period_valid=0.

Source files
------------

// File: rtl/clk_monitor_pkg.sv
// rtl/clk_monitor_pkg.sv - shared FSM state type, default timing constants and tolerance helper
package clk_monitor_pkg;

  localparam int unsigned DEF_EXP_CYCLES = 32'd50000000;
  localparam int unsigned DEF_TOL_CYCLES = 32'd500000;
  localparam int          DEF_CNT_W      = 27;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOST    = 2'd2
  } mon_state_t;

  // Subtract the smaller from the larger so the deviation never wraps.
  function automatic logic within_tol(input logic [31:0] p, input logic [31:0] e,
                                      input logic [31:0] t);
    if (p >= e) return (p - e) <= t;
    else        return (e - p) <= t;
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// rtl/sync_rise_detect.sv - two-flop synchronizer plus rising-edge detector for a slow async input
module sync_rise_detect (
  input  logic clk,
  input  logic reset_button,
  input  logic async_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk) begin
    if (!reset_button) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/clk_monitor.sv
// rtl/clk_monitor.sv - measures the period of a slow clock in system-clock cycles and flags loss
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int unsigned EXP_CYCLES = DEF_EXP_CYCLES,
  parameter int unsigned TOL_CYCLES = DEF_TOL_CYCLES,
  parameter int          CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_button,
  input  logic             clk_in,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             lost
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EXP_CYCLES + TOL_CYCLES);

  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] meas;
  logic             meas_ok;
  logic             at_max;
  mon_state_t       state;

  sync_rise_detect u_sync (
    .clk          (clk),
    .reset_button (reset_button),
    .async_in     (clk_in),
    .rise         (rise)
  );

  // cnt counts cycles since the last rise, so the interval is one more than cnt.
  assign meas    = cnt + CNT_W'(1);
  assign meas_ok = within_tol(32'(meas), 32'(EXP_CYCLES), 32'(TOL_CYCLES));
  assign at_max  = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!reset_button) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      tick         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      lost         <= 1'b0;
    end else begin
      tick         <= rise;
      period_valid <= 1'b0;

      if (rise)         cnt <= '0;
      else if (!at_max) cnt <= cnt + CNT_W'(1);

      case (state)
        ST_IDLE: begin
          if (rise) begin
            state <= ST_MEASURE;
          end else if (at_max) begin
            state    <= ST_LOST;
            lost     <= 1'b1;
            in_range <= 1'b0;
          end
        end
        ST_MEASURE: begin
          // A rise on the saturation cycle still counts as a (too long) period.
          if (rise) begin
            period       <= meas;
            period_valid <= 1'b1;
            in_range     <= meas_ok;
          end else if (at_max) begin
            state    <= ST_LOST;
            lost     <= 1'b1;
            in_range <= 1'b0;
          end
        end
        ST_LOST: begin
          if (rise) begin
            state <= ST_MEASURE;
            lost  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// tb/tb_clk_monitor.sv - table, directed and random checks of clk_monitor against an event-level model
module tb_clk_monitor;

  localparam int EXP = 100;
  localparam int TOL = 5;
  localparam int SAT = EXP + TOL;

  logic       clk;
  logic       reset_button;
  logic       clk_in;
  logic       tick;
  logic [7:0] period;
  logic       period_valid;
  logic       in_range;
  logic       lost;

  clk_monitor #(.EXP_CYCLES(EXP), .TOL_CYCLES(TOL), .CNT_W(8)) dut (
    .clk          (clk),
    .reset_button (reset_button),
    .clk_in       (clk_in),
    .tick         (tick),
    .period       (period),
    .period_valid (period_valid),
    .in_range     (in_range),
    .lost         (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: clk_in sample history per edge, plus anchor-based timing.
  bit h_q[$];
  bit r_q[$];
  int m_phase;   // 0 idle, 1 measuring, 2 lost
  int m_anchor;
  int m_tick, m_pv, m_period, m_inr, m_lost;

  int pv_seen, pv_period, pv_inr, tick_seen;

  typedef struct {
    int len;
    int exp_inr;
  } vec_t;
  vec_t tab[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit c, input bit rst);
    int n;
    int dev;
    bit t;
    n = h_q.size();
    t = !rst && n >= 3 && !r_q[n-1] && h_q[n-2] && !h_q[n-3];
    h_q.push_back(rst ? 1'b0 : c);
    r_q.push_back(rst);
    if (rst) begin
      m_phase = 0; m_anchor = n;
      m_tick = 0; m_pv = 0; m_period = 0; m_inr = 0; m_lost = 0;
    end else begin
      m_tick = t;
      m_pv = 0;
      if (t) begin
        if (m_phase == 1) begin
          m_period = n - m_anchor;
          dev = (m_period > EXP) ? m_period - EXP : EXP - m_period;
          m_pv = 1;
          m_inr = (dev <= TOL);
        end
        m_lost = 0;
        m_phase = 1;
        m_anchor = n;
      end else if (m_phase != 2 && n - m_anchor == SAT + 1) begin
        m_phase = 2;
        m_lost = 1;
        m_inr = 0;
      end
    end
  endtask

  task automatic step(input bit c, input bit rst);
    @(negedge clk);
    clk_in = c;
    reset_button = ~rst;
    @(posedge clk);
    #1;
    model_edge(c, rst);
    chk("tick", int'(tick), m_tick);
    chk("period_valid", int'(period_valid), m_pv);
    chk("period", int'(period), m_period);
    chk("in_range", int'(in_range), m_inr);
    chk("lost", int'(lost), m_lost);
    if (period_valid) begin
      pv_seen = 1;
      pv_period = int'(period);
      pv_inr = int'(in_range);
    end
    if (tick) tick_seen = 1;
  endtask

  task automatic pulse(input int len, input int hi);
    for (int i = 0; i < len; i++) step(i < hi, 1'b0);
  endtask

  initial begin
    int ticks_at[4];
    int len, hi, sel;

    tab[0] = '{100, 1}; tab[1] = '{105, 1}; tab[2] = '{106, 0}; tab[3] = '{95, 1};
    tab[4] = '{94, 0};  tab[5] = '{96, 1};  tab[6] = '{90, 0};  tab[7] = '{101, 1};

    clk_in = 1'b0;
    reset_button = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("rst_period", int'(period), 0);
    chk("rst_lost", int'(lost), 0);
    chk("rst_in_range", int'(in_range), 0);

    // First rise after reset: tick only.
    pv_seen = 0; tick_seen = 0;
    pulse(tab[0].len, 50);
    chk("first_rise_pv", pv_seen, 0);
    chk("first_rise_tick", tick_seen, 1);

    for (int i = 1; i <= 8; i++) begin
      pv_seen = 0;
      pulse((i < 8) ? tab[i].len : 100, 40);
      chk("tab_pv", pv_seen, 1);
      chk("tab_period", pv_period, tab[i-1].len);
      chk("tab_in_range", pv_inr, tab[i-1].exp_inr);
    end

    // clk_in stops: lost, period held.
    for (int i = 0; i < 110; i++) step(1'b0, 1'b0);
    chk("lost_set", int'(lost), 1);
    chk("lost_period_held", int'(period), tab[7].len);
    chk("lost_in_range", int'(in_range), 0);

    // Recovery from lost.
    pv_seen = 0; tick_seen = 0;
    pulse(100, 50);
    chk("recover_pv", pv_seen, 0);
    chk("recover_tick", tick_seen, 1);
    chk("recover_lost", int'(lost), 0);
    pv_seen = 0;
    pulse(100, 50);
    chk("recover2_pv", pv_seen, 1);
    chk("recover2_period", pv_period, 100);
    chk("recover2_in_range", pv_inr, 1);

    // Reset mid-measurement.
    for (int i = 0; i < 48; i++) step(i < 20, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("midrst_period", int'(period), 0);
    chk("midrst_lost", int'(lost), 0);
    chk("midrst_tick", int'(tick), 0);
    pv_seen = 0;
    pulse(100, 50);
    chk("midrst_next_pv", pv_seen, 0);

    // clk_in high across reset release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    pv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      ticks_at[i] = int'(tick);
    end
    chk("hirst_tick1", ticks_at[0], 0);
    chk("hirst_tick2", ticks_at[1], 0);
    chk("hirst_tick3", ticks_at[2], 1);
    chk("hirst_tick4", ticks_at[3], 0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
    chk("hirst_pv", pv_seen, 0);

    // Random periods, including short and lost intervals.
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      len = $urandom_range(90, 110);
      else if (sel < 8) len = $urandom_range(6, 40);
      else              len = $urandom_range(107, 140);
      hi = $urandom_range(1, len - 1);
      pulse(len, hi);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
